instr_fetch_unit: RTL and testbench

- Fetch front end that sits directly upstream of the single-cycle LEGv8 datapath.
- Owns the PC and issues word reads to instruction memory (1-cycle read latency).
- Buffers returned words in a small prefetch FIFO and hands them to decode over a valid/ready handshake.
- Accepts branch redirects (CBZ taken, B) from the datapath, flushing stale fetches.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 50 +++++
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 fetch front end (instr_fetch_unit) and its bench.
package fetch_pkg;
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOP_WORD    = 32'h0;
    localparam int          INSTR_BYTES = 4;
    localparam logic [5:0]  OP_B        = 6'b000101;
    localparam logic [7:0]  OP_CBZ      = 8'b10110100;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO: registered storage, flush clears occupancy, head word visible on o_rdata.
module fetch_fifo #(
    parameter  int WIDTH = 96,
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic [AW:0]      o_count,
    output logic             o_empty
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push, w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign w_push  = i_push && ((r_count != FULL_CNT) || w_pop);
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

    always_ff @(posedge CLK) begin
        if (w_push && !i_flush && RST)
            r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge CLK) begin
        if (!RST || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch front end: PC, 1-cycle imem reads, prefetch FIFO, redirect/halt/fault control.
// Define FETCH_PERF_EN to add the perf_fetched / perf_squashed counters.
module instr_fetch_unit import fetch_pkg::*; #(
    parameter int                ADDR_W     = 64,
    parameter int                IMEM_BYTES = 64,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic              CLK,
    input  logic              RST,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              halted,
    output logic              fault
`ifdef FETCH_PERF_EN
   ,output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_squashed
`endif
);
    localparam int                CW       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]       DEPTH_C  = (CW+1)'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] IMEM_END = ADDR_W'(IMEM_BYTES);

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_pc, r_inflight_pc;
    logic              r_inflight, r_epoch, r_req_epoch, r_halted, r_fault;

    logic [CW-1:0]        w_count;
    logic                 w_empty, w_push, w_pop, w_redirect, w_misalign, w_in_range;
    logic [CW:0]          w_slots;
    logic [ADDR_W+31:0]   w_head;

    assign w_redirect = redirect_valid && (r_state != ST_FAULT);
    assign w_misalign = (redirect_pc[1:0] != 2'b00);
    assign w_in_range = (r_pc < IMEM_END);
    assign w_pop      = inst_valid && inst_ready && !w_redirect;
    // A response is stale if a redirect toggled the epoch after it was issued.
    assign w_push     = r_inflight && (r_req_epoch == r_epoch) && !w_redirect;
    assign w_slots    = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);

    assign imem_req  = RST && (r_state == ST_FETCH) && !redirect_valid && w_in_range && (w_slots < DEPTH_C);
    assign imem_addr = r_pc;

    assign inst_valid = !w_empty;
    assign inst_data  = inst_valid ? w_head[31:0] : NOP_WORD;
    assign inst_pc    = inst_valid ? w_head[ADDR_W+31:32] : '0;
    assign halted     = r_halted;
    assign fault      = r_fault;

    fetch_fifo #(.WIDTH(ADDR_W + 32), .DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_redirect),
        .i_wdata ({r_inflight_pc, imem_rdata}),
        .o_rdata (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state       <= ST_FETCH;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_epoch       <= 1'b0;
            r_req_epoch   <= 1'b0;
            r_halted      <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_pc          <= r_pc + ADDR_W'(INSTR_BYTES);
                r_inflight_pc <= r_pc;
                r_req_epoch   <= r_epoch;
            end
            if (w_redirect) begin
                r_epoch  <= ~r_epoch;
                r_pc     <= redirect_pc;
                r_halted <= 1'b0;
                if (w_misalign) begin
                    r_state <= ST_FAULT;
                    r_fault <= 1'b1;
                end else begin
                    r_state <= ST_FETCH;
                end
            end else if (r_state == ST_FETCH && !w_in_range && w_empty && !r_inflight) begin
                r_state  <= ST_HALT;
                r_halted <= 1'b1;
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] r_perf_fetched, r_perf_squashed;
    logic [32:0] w_fetched_sum, w_squash_sum;

    // Squash count covers queued words plus the response landing this cycle.
    assign w_fetched_sum = {1'b0, r_perf_fetched} + 33'(w_pop);
    assign w_squash_sum  = {1'b0, r_perf_squashed} + 33'(w_count) + 33'(r_inflight);
    assign perf_fetched  = r_perf_fetched;
    assign perf_squashed = r_perf_squashed;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_perf_fetched  <= '0;
            r_perf_squashed <= '0;
        end else begin
            if (w_pop)
                r_perf_fetched <= w_fetched_sum[32] ? '1 : w_fetched_sum[31:0];
            if (w_redirect)
                r_perf_squashed <= w_squash_sum[32] ? '1 : w_squash_sum[31:0];
        end
    end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: spec-level stream scoreboard with random ready/program.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    import fetch_pkg::*;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0, RST = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        inst_valid, inst_ready = 1'b0;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        halted, fault;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_squashed;
`endif

    int n_checks = 0, n_pass = 0;
    int n_issued = 0, n_popped = 0;
    logic [31:0] mem [16];
    logic        s_req, s_valid, s_halted, s_fault;
    logic [63:0] s_addr, s_pc;
    logic [31:0] s_data;

    instr_fetch_unit #(.ADDR_W(64), .IMEM_BYTES(64), .FIFO_DEPTH(DEPTH), .RESET_PC(64'h0)) dut (
        .CLK(CLK), .RST(RST), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc), .halted(halted), .fault(fault)
`ifdef FETCH_PERF_EN
       ,.perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
    );

    always #5 CLK = ~CLK;

    // Memory answers one cycle after a request; junk otherwise so mistimed captures show up.
    always @(posedge CLK) imem_rdata <= imem_req ? mem[imem_addr[5:2]] : 32'hDEAD_BEEF;

    task automatic tick(input logic rst, input logic rdy, input logic rv, input logic [63:0] rpc);
        @(negedge CLK);
        RST = rst; inst_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        #1;
        s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid; s_pc = inst_pc;
        s_data = inst_data; s_halted = halted; s_fault = fault;
        if (s_req) n_issued++;
        if (rst && !rv && s_valid && rdy) n_popped++;
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        tick(1'b0, 1'b0, 1'b0, 64'h0);
        n_issued = 0; n_popped = 0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 16; i++)
            case ($urandom_range(0, 2))
                0:       mem[i] = {OP_B, 26'($urandom)};
                1:       mem[i] = {OP_CBZ, 24'($urandom)};
                default: mem[i] = $urandom;
            endcase
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if ({s_req, s_valid, s_halted, s_fault} !== 4'b0) $display("FAIL reset_flags: got req/valid/halted/fault=%b want 0000", {s_req, s_valid, s_halted, s_fault}); else n_pass++;
        n_checks++; if (s_addr !== 64'h0) $display("FAIL reset_addr: got %h want 0", s_addr); else n_pass++;
        n_checks++; if ({s_data, s_pc} !== 96'h0) $display("FAIL reset_inst: got data=%h pc=%h want 0/0", s_data, s_pc); else n_pass++;
`ifdef FETCH_PERF_EN
        n_checks++; if ({perf_fetched, perf_squashed} !== 64'h0) $display("FAIL reset_perf: got %h/%h want 0/0", perf_fetched, perf_squashed); else n_pass++;
`endif
    endtask

    task automatic test_stream();
        logic [63:0] exp_pc;
        for (int i = 0; i < 16; i++) mem[i] = 32'h8B02_0020 + 32'(i);
        do_reset();
        exp_pc = 64'h0;
        for (int k = 0; k < 18; k++) begin
            tick(1'b1, 1'b1, 1'b0, 64'h0);
            if (k == 0) begin
                n_checks++; if (!(s_req === 1'b1 && s_addr === 64'h0)) $display("FAIL stream_first_req: got req=%b addr=%h want 1/0", s_req, s_addr); else n_pass++;
            end else if (k == 1) begin
                n_checks++; if (s_valid !== 1'b0) $display("FAIL stream_latency: got valid=%b at cycle 1 want 0", s_valid); else n_pass++;
            end else begin
                n_checks++;
                if ({s_valid, s_pc, s_data} !== {1'b1, exp_pc, mem[exp_pc[5:2]]})
                    $display("FAIL stream_word: cycle %0d got v=%b pc=%h d=%h want pc=%h d=%h", k, s_valid, s_pc, s_data, exp_pc, mem[exp_pc[5:2]]);
                else n_pass++;
                exp_pc += 64'd4;
            end
        end
        for (int i = 0; i < 8 && !s_halted; i++) tick(1'b1, 1'b1, 1'b0, 64'h0);
        n_checks++; if ({s_halted, s_req, s_valid} !== 3'b100) $display("FAIL stream_halt: got halted/req/valid=%b want 100", {s_halted, s_req, s_valid}); else n_pass++;
        n_checks++; if (n_issued != 16) $display("FAIL stream_issued: got %0d want 16", n_issued); else n_pass++;
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetched !== 32'd16) $display("FAIL stream_perf: got %0d want 16", perf_fetched); else n_pass++;
`endif
    endtask

    task automatic test_stall();
        logic [63:0] exp_pc, hold_pc;
        logic [31:0] hold_data;
        logic        hold, rdy;
        fill_random();
        do_reset();
        for (int i = 0; i < 10 && !s_valid; i++) tick(1'b1, 1'b0, 1'b0, 64'h0);
        n_checks++; if (s_valid !== 1'b1) $display("FAIL stall_first_valid: got %b want 1", s_valid); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b0, 1'b0, 64'h0);
            n_checks++; if ({s_valid, s_pc, s_data} !== {1'b1, 64'h0, mem[0]}) $display("FAIL stall_hold: got v=%b pc=%h d=%h want 1/0/%h", s_valid, s_pc, s_data, mem[0]); else n_pass++;
        end
        n_checks++; if (n_issued > DEPTH) $display("FAIL stall_issued: got %0d want <= %0d", n_issued, DEPTH); else n_pass++;
        exp_pc = 64'h0; hold = 1'b1; hold_pc = 64'h0; hold_data = mem[0];
        for (int i = 0; i < 300 && !s_halted; i++) begin
            rdy = 1'($urandom_range(0, 1));
            tick(1'b1, rdy, 1'b0, 64'h0);
            if (hold) begin
                n_checks++; if ({s_valid, s_pc, s_data} !== {1'b1, hold_pc, hold_data}) $display("FAIL stall_stable: got v=%b pc=%h d=%h want 1/%h/%h", s_valid, s_pc, s_data, hold_pc, hold_data); else n_pass++;
            end
            if (s_valid) begin
                n_checks++; if ({s_pc, s_data} !== {exp_pc, mem[exp_pc[5:2]]}) $display("FAIL stall_order: got pc=%h d=%h want pc=%h d=%h", s_pc, s_data, exp_pc, mem[exp_pc[5:2]]); else n_pass++;
                if (rdy) exp_pc += 64'd4;
            end
            hold = s_valid && !rdy; hold_pc = s_pc; hold_data = s_data;
        end
        n_checks++; if (!(s_halted === 1'b1 && exp_pc == 64'd64)) $display("FAIL stall_drain: got halted=%b next_pc=%h want 1/40", s_halted, exp_pc); else n_pass++;
    endtask

    task automatic test_redirect();
        fill_random();
        do_reset();
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1'b0, 64'h0);
        tick(1'b1, 1'b0, 1'b0, 64'h0);
        tick(1'b1, 1'b0, 1'b1, 64'h20);
        n_checks++; if ({s_valid, s_pc} !== {1'b1, 64'h8}) $display("FAIL redir_setup: got v=%b pc=%h want 1/8", s_valid, s_pc); else n_pass++;
        n_checks++; if (n_issued - n_popped != 3) $display("FAIL redir_outstanding: got %0d want 3", n_issued - n_popped); else n_pass++;
        tick(1'b1, 1'b1, 1'b0, 64'h0);
        n_checks++; if ({s_valid, s_req, s_addr} !== {1'b0, 1'b1, 64'h20}) $display("FAIL redir_restart: got v=%b req=%b addr=%h want 0/1/20", s_valid, s_req, s_addr); else n_pass++;
`ifdef FETCH_PERF_EN
        n_checks++; if ({perf_fetched, perf_squashed} !== {32'd2, 32'd3}) $display("FAIL redir_perf: got fetched=%0d squashed=%0d want 2/3", perf_fetched, perf_squashed); else n_pass++;
`endif
        for (int i = 0; i < 6 && !s_valid; i++) tick(1'b1, 1'b1, 1'b0, 64'h0);
        n_checks++; if ({s_valid, s_pc, s_data} !== {1'b1, 64'h20, mem[8]}) $display("FAIL redir_target: got v=%b pc=%h d=%h want 1/20/%h", s_valid, s_pc, s_data, mem[8]); else n_pass++;
    endtask

    task automatic test_redirect_pop();
        logic [63:0] tgt;
        logic        seen;
        fill_random();
        do_reset();
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b1, 1'b0, 64'h0);
        tgt = {58'h0, 4'($urandom_range(0, 15)), 2'b00};
        tick(1'b1, 1'b1, 1'b1, tgt);
        n_checks++; if (s_valid !== 1'b1) $display("FAIL rpop_setup: got valid=%b want 1", s_valid); else n_pass++;
        tick(1'b1, 1'b1, 1'b0, 64'h0);
        n_checks++; if ({s_valid, s_req, s_addr} !== {1'b0, 1'b1, tgt}) $display("FAIL rpop_flush: got v=%b req=%b addr=%h want 0/1/%h", s_valid, s_req, s_addr, tgt); else n_pass++;
`ifdef FETCH_PERF_EN
        n_checks++; if (perf_fetched !== 32'(n_popped)) $display("FAIL rpop_perf: got %0d want %0d", perf_fetched, n_popped); else n_pass++;
`endif
        for (int i = 0; i < 6 && !s_valid; i++) tick(1'b1, 1'b1, 1'b0, 64'h0);
        n_checks++; if ({s_valid, s_pc} !== {1'b1, tgt}) $display("FAIL rpop_target: got v=%b pc=%h want 1/%h", s_valid, s_pc, tgt); else n_pass++;
        tick(1'b1, 1'b1, 1'b1, 64'h40);
        seen = 1'b0;
        for (int i = 0; i < 8 && !s_halted; i++) begin
            tick(1'b1, 1'b1, 1'b0, 64'h0);
            seen |= s_valid | s_req;
        end
        n_checks++; if ({s_halted, seen} !== 2'b10) $display("FAIL rpop_rehalt: got halted=%b activity=%b want 1/0", s_halted, seen); else n_pass++;
        tick(1'b1, 1'b1, 1'b1, 64'h4);
        tick(1'b1, 1'b1, 1'b0, 64'h0);
        n_checks++; if ({s_halted, s_req, s_addr} !== {1'b0, 1'b1, 64'h4}) $display("FAIL rpop_unhalt: got halted=%b req=%b addr=%h want 0/1/4", s_halted, s_req, s_addr); else n_pass++;
    endtask

    task automatic test_fault();
        tick(1'b1, 1'b1, 1'b1, 64'h22);
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'($urandom_range(0, 1)), (i == 2), 64'h0);
            n_checks++; if ({s_fault, s_req, s_valid} !== 3'b100) $display("FAIL fault_sticky: cycle %0d got fault/req/valid=%b want 100", i, {s_fault, s_req, s_valid}); else n_pass++;
        end
        do_reset();
        n_checks++; if (s_fault !== 1'b0) $display("FAIL fault_clear: got %b want 0", s_fault); else n_pass++;
    endtask

    task automatic test_reset_mid();
        fill_random();
        do_reset();
        for (int k = 0; k < 8; k++) tick(1'b1, 1'b0, 1'b0, 64'h0);
        n_checks++; if (!(n_issued == DEPTH && s_req === 1'b0 && s_valid === 1'b1)) $display("FAIL rmid_full: got issued=%0d req=%b valid=%b want %0d/0/1", n_issued, s_req, s_valid, DEPTH); else n_pass++;
        tick(1'b0, 1'b1, 1'b0, 64'h0);
        tick(1'b0, 1'b1, 1'b0, 64'h0);
        n_checks++; if ({s_req, s_valid, s_halted, s_fault, s_data, s_pc, s_addr} !== 164'h0) $display("FAIL rmid_outputs: got req=%b v=%b d=%h pc=%h addr=%h want all 0", s_req, s_valid, s_data, s_pc, s_addr); else n_pass++;
        n_issued = 0; n_popped = 0;
        tick(1'b1, 1'b1, 1'b0, 64'h0);
        n_checks++; if ({s_req, s_addr} !== {1'b1, 64'h0}) $display("FAIL rmid_refetch: got req=%b addr=%h want 1/0", s_req, s_addr); else n_pass++;
        for (int i = 0; i < 6 && !s_valid; i++) tick(1'b1, 1'b1, 1'b0, 64'h0);
        n_checks++; if ({s_valid, s_pc, s_data} !== {1'b1, 64'h0, mem[0]}) $display("FAIL rmid_first: got v=%b pc=%h d=%h want 1/0/%h", s_valid, s_pc, s_data, mem[0]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_fault();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
